// File: rtl/alu_main_if.sv
// -----------------------------------------------------------------------------
// alu_main_if
// Purpose : groups the control, operand and result signals of the registered
//           8-bit ALU so they travel as one bundle. Clock and reset are not
//           part of the bundle.
// Signals : on        - enable; low forces the controller to OFF
//           in_sel    - [2]=persist, [1]=load, [0]=soft clear
//           num1/num2 - operand inputs
//           out_sel   - one-hot operation select (lowest set bit wins)
//           out       - registered ALU result
//           currState - registered controller state
//           nextState - combinational next controller state
// Modports: master - drives control/operands, observes results (stimulus side)
//           slave  - the ALU itself
// -----------------------------------------------------------------------------
interface alu_main_if;
   logic       on;
   logic [2:0] in_sel;
   logic [7:0] num1;
   logic [7:0] num2;
   logic [6:0] out_sel;
   logic [7:0] out;
   logic [1:0] currState;
   logic [1:0] nextState;

   modport master (
      output on, in_sel, num1, num2, out_sel,
      input  out, currState, nextState
   );

   modport slave (
      input  on, in_sel, num1, num2, out_sel,
      output out, currState, nextState
   );
endinterface : alu_main_if

// File: rtl/alu_main.sv
// -----------------------------------------------------------------------------
// alu_main
// Purpose : 8-bit registered ALU driven by a 2-bit controller. Operands are
//           captured into internal registers on a load, and the result register
//           is refreshed every edge according to the controller's next state:
//             OFF     -> 0
//             IDLE    -> f(A,B) with the current out_sel (0 on soft clear)
//             LOAD    -> f(num1,num2), and A/B capture num1/num2
//             PERSIST -> hold
// Ports   : clk  - system clock, all state updates on the rising edge
//           rst  - synchronous, active-high reset
//           bus  - alu_main_if.slave (on, in_sel, num1, num2, out_sel in;
//                  out, currState, nextState out)
// Latency : a result is visible on out one edge after its inputs are sampled.
// -----------------------------------------------------------------------------
module alu_main (
   input  logic       clk,
   input  logic       rst,
   alu_main_if.slave  bus
);

   typedef enum logic [1:0] {
      OFF     = 2'b00,
      IDLE    = 2'b01,
      LOAD    = 2'b10,
      PERSIST = 2'b11
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic [7:0] a_q;
   logic [7:0] a_d;
   logic [7:0] b_q;
   logic [7:0] b_d;
   logic [7:0] out_q;
   logic [7:0] out_d;
   logic       soft_clr;
   logic [7:0] f_stored;
   logic [7:0] f_inputs;

   // Operation decode. out_sel is nominally one-hot; when several bits are set
   // the lowest one wins, and an all-zero select yields zero. Arithmetic is
   // modulo 256 because the result is simply truncated to 8 bits.
   function automatic logic [7:0] alu_f(input logic [6:0] sel,
                                        input logic [7:0] x,
                                        input logic [7:0] y);
      logic [7:0] r;
      r = 8'h00;
      if (sel[0])      r = x + y;
      else if (sel[1]) r = x - y;
      else if (sel[2]) r = x & y;
      else if (sel[3]) r = x | y;
      else if (sel[4]) r = x ^ y;
      else if (sel[5]) r = ~x;
      else if (sel[6]) r = {x[6:0], 1'b0};
      return r;
   endfunction

   assign f_stored = alu_f(bus.out_sel, a_q, b_q);
   assign f_inputs = alu_f(bus.out_sel, bus.num1, bus.num2);

   // Soft clear only counts while enabled and not in reset; both rst and on=0
   // take priority over every in_sel bit.
   assign soft_clr = !rst && bus.on && bus.in_sel[0];

   // ---------------------------------------------------------------------
   // Next-state logic. The same priority applies from every current state,
   // so the present state does not enter the decision.
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = IDLE;
      if (rst)                 state_d = OFF;
      else if (!bus.on)        state_d = OFF;
      else if (bus.in_sel[0])  state_d = IDLE;
      else if (bus.in_sel[1])  state_d = LOAD;
      else if (bus.in_sel[2])  state_d = PERSIST;
      else                     state_d = IDLE;
   end

   // ---------------------------------------------------------------------
   // Operand and result next values, all keyed off the next state so that the
   // registered outputs describe the state being entered on this edge.
   // ---------------------------------------------------------------------
   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      out_d = out_q;

      // Operands survive OFF (on=0); only reset or soft clear wipes them.
      if (rst || soft_clr) begin
         a_d = 8'h00;
         b_d = 8'h00;
      end else if (state_d == LOAD) begin
         a_d = bus.num1;
         b_d = bus.num2;
      end

      case (state_d)
         OFF:     out_d = 8'h00;
         IDLE:    out_d = soft_clr ? 8'h00 : f_stored;
         LOAD:    out_d = f_inputs;
         PERSIST: out_d = out_q;
         default: out_d = 8'h00;
      endcase
   end

   // Reset is repeated explicitly here even though state_d/out_d already
   // resolve to OFF/0 under rst, so the register reset values are obvious.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= OFF;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         out_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         out_q   <= out_d;
      end
   end

   assign bus.out       = out_q;
   assign bus.currState = state_q;
   assign bus.nextState = state_d;

endmodule : alu_main

// File: tb/tb_alu_main.sv
// -----------------------------------------------------------------------------
// tb_alu_main
// Directed bench for alu_main. Each step drives inputs on the falling edge,
// checks the combinational nextState, pushes the expected {out,currState}
// into a scoreboard queue, and after the next rising edge pops and compares.
// -----------------------------------------------------------------------------
module tb_alu_main;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   step_no;

   logic [9:0] sb_q[$];

   alu_main_if bus ();

   alu_main dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [6:0] OP_ADD = 7'b0000001;
   localparam logic [6:0] OP_SUB = 7'b0000010;
   localparam logic [6:0] OP_AND = 7'b0000100;
   localparam logic [6:0] OP_OR  = 7'b0001000;
   localparam logic [6:0] OP_XOR = 7'b0010000;
   localparam logic [6:0] OP_NOT = 7'b0100000;
   localparam logic [6:0] OP_SHL = 7'b1000000;

   task automatic step(input logic       r,
                       input logic       o,
                       input logic [2:0] is,
                       input logic [7:0] n1,
                       input logic [7:0] n2,
                       input logic [6:0] os,
                       input logic [7:0] exp_out,
                       input logic [1:0] exp_st);
      logic [9:0] exp_v;
      @(negedge clk);
      rst         = r;
      bus.on      = o;
      bus.in_sel  = is;
      bus.num1    = n1;
      bus.num2    = n2;
      bus.out_sel = os;
      #1;
      checks++;
      assert (bus.nextState === exp_st) else begin
         failures++;
         $error("FAIL step%0d nextState observed=%b expected=%b", step_no, bus.nextState, exp_st);
      end
      sb_q.push_back({exp_out, exp_st});
      @(posedge clk);
      #1;
      exp_v = sb_q.pop_front();
      checks++;
      assert (bus.out === exp_v[9:2]) else begin
         failures++;
         $error("FAIL step%0d out observed=%h expected=%h", step_no, bus.out, exp_v[9:2]);
      end
      checks++;
      assert (bus.currState === exp_v[1:0]) else begin
         failures++;
         $error("FAIL step%0d currState observed=%b expected=%b", step_no, bus.currState, exp_v[1:0]);
      end
      $display("step%0d rst=%b on=%b in_sel=%b num1=%h num2=%h out_sel=%b -> out=%h state=%b",
               step_no, r, o, is, n1, n2, os, bus.out, bus.currState);
      step_no++;
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      step_no     = 0;
      rst         = 1'b1;
      bus.on      = 1'b0;
      bus.in_sel  = 3'b000;
      bus.num1    = 8'h00;
      bus.num2    = 8'h00;
      bus.out_sel = 7'b0;

      // Reset for two cycles; a load request underneath must be ignored.
      step(1'b1, 1'b1, 3'b010, 8'h57, 8'h1A, OP_OR, 8'h00, 2'b00);
      step(1'b1, 1'b1, 3'b010, 8'h57, 8'h1A, OP_OR, 8'h00, 2'b00);

      // Load with OR, then recompute from stored operands (num inputs ignored).
      step(1'b0, 1'b1, 3'b010, 8'h57, 8'h1A, OP_OR,  8'h5F, 2'b10);
      step(1'b0, 1'b1, 3'b000, 8'h00, 8'h01, OP_SUB, 8'h3D, 2'b01);
      step(1'b0, 1'b1, 3'b000, 8'h00, 8'h01, OP_AND, 8'h12, 2'b01);
      step(1'b0, 1'b1, 3'b000, 8'hC3, 8'h99, OP_XOR, 8'h4D, 2'b01);
      step(1'b0, 1'b1, 3'b000, 8'h00, 8'h00, OP_NOT, 8'hA8, 2'b01);
      step(1'b0, 1'b1, 3'b000, 8'h00, 8'h00, OP_SHL, 8'hAE, 2'b01);
      step(1'b0, 1'b1, 3'b000, 8'h00, 8'h00, 7'b0,   8'h00, 2'b01);
      // Non-one-hot select: bits 6 and 3 set, lowest (OR) wins.
      step(1'b0, 1'b1, 3'b000, 8'h00, 8'h00, 7'b1001000, 8'h5F, 2'b01);

      // Persist holds 5F regardless of operands/select.
      step(1'b0, 1'b1, 3'b100, 8'hAA, 8'h55, OP_SUB, 8'h5F, 2'b11);
      step(1'b0, 1'b1, 3'b100, 8'h12, 8'h34, OP_ADD, 8'h5F, 2'b11);
      step(1'b0, 1'b1, 3'b100, 8'hFF, 8'hFF, OP_NOT, 8'h5F, 2'b11);

      // Load outranks persist; wrap-around add then borrow on subtract.
      step(1'b0, 1'b1, 3'b110, 8'hFF, 8'h02, OP_ADD, 8'h01, 2'b10);
      step(1'b0, 1'b1, 3'b000, 8'h00, 8'h00, OP_SUB, 8'hFD, 2'b01);

      // on=0 forces OFF even with a load request; operands are retained.
      step(1'b0, 1'b0, 3'b010, 8'h11, 8'h22, OP_ADD, 8'h00, 2'b00);
      step(1'b0, 1'b1, 3'b000, 8'h00, 8'h00, OP_ADD, 8'h01, 2'b01);

      // Soft clear beats load; cleared operands then give ~0 = FF.
      step(1'b0, 1'b1, 3'b011, 8'h77, 8'h88, OP_ADD, 8'h00, 2'b01);
      step(1'b0, 1'b1, 3'b000, 8'h00, 8'h00, OP_NOT, 8'hFF, 2'b01);

      // Non-one-hot load (AND wins), then reset mid-operation clears operands.
      step(1'b0, 1'b1, 3'b010, 8'h0F, 8'h3C, 7'b0010100, 8'h0C, 2'b10);
      step(1'b1, 1'b1, 3'b010, 8'hF0, 8'h0F, OP_OR, 8'h00, 2'b00);
      step(1'b0, 1'b1, 3'b000, 8'h00, 8'h00, OP_NOT, 8'hFF, 2'b01);

      checks++;
      assert (sb_q.size() == 0) else begin
         failures++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_alu_main
